// File: rtl/score_pkg.sv
// Shared constants, FSM encoding and 7-segment patterns for the score BCD display path.
package score_pkg;

  localparam int SCORE_W = 8;
  localparam int DIGITS  = 3;
  localparam int BCD_W   = DIGITS * 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Active-low segments, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern, with forced blanking.
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg_pattern(digit);

endmodule

// File: rtl/score_bcd_display.sv
// Score to BCD converter (iterative double dabble), re-triggered when the score changes.
// Optional 4-digit multiplexed 7-segment driver enabled by defining SCORE_SEG7_EN.
module score_bcd_display #(
  parameter int SCORE_W     = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy
`ifdef SCORE_SEG7_EN
  ,
  output logic [6:0]            seg,
  output logic [3:0]            an,
  output logic                  dp
`endif
);
  import score_pkg::*;

  localparam int ACC_W = DIGITS * 4;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] bin;
  logic [SCORE_W-1:0] last_score;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bin        <= '0;
      last_score <= '0;
      acc        <= '0;
      bcd        <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (score != last_score) begin
            bin        <= score;
            last_score <= score;
            acc        <= '0;
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= {acc_adj[ACC_W-2:0], bin[SCORE_W-1]};
          bin <= {bin[SCORE_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(SCORE_W - 1)) state <= DONE;
        end
        DONE: begin
          bcd       <= acc;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_SEG7_EN
  localparam int RC_W = $clog2(REFRESH_DIV + 1);

  logic [RC_W-1:0] rc;
  logic [1:0]      slot;
  logic [3:0]      dig;
  logic            blank;
  logic [6:0]      seg_d;

  // Leading-zero blanking; slot 3 has no digit behind it
  always_comb begin
    dig   = 4'd0;
    blank = 1'b1;
    case (slot)
      2'd0: begin dig = bcd[3:0];  blank = 1'b0; end
      2'd1: begin dig = bcd[7:4];  blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0); end
      2'd2: begin dig = bcd[11:8]; blank = (bcd[11:8] == 4'd0); end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .digit (dig),
    .blank (blank),
    .seg   (seg_d)
  );

  assign dp = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rc   <= '0;
      slot <= 2'd0;
      seg  <= SEG_BLANK;
      an   <= 4'hF;
    end else begin
      if (rc == RC_W'(REFRESH_DIV - 1)) begin
        rc   <= '0;
        slot <= slot + 2'd1;
      end else begin
        rc <= rc + 1'b1;
      end
      seg <= seg_d;
      an  <= (slot == 2'd3) ? 4'hF : ~(4'b0001 << slot);
    end
  end
`else
  logic unused_refresh;
  assign unused_refresh = (REFRESH_DIV > 0);
`endif

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
Consumer end of the score path: reads the 8-bit score from the score counter and converts it to three BCD digits for on-screen or 7-segment display. Conversion is an iterative shift-add-3 (double dabble) FSM, started automatically whenever the sampled score differs from the last converted value. Sits between the score counter and the text/overlay renderer; optionally drives the board's 4-digit 7-segment display directly.

Parameters:
SCORE_W, 8, width of the score input (max 255).
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^SCORE_W - 1.
REFRESH_DIV, 100000, clk cycles per 7-seg digit slot (1 kHz at 100 MHz); used only with the optional feature.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
score  in  SCORE_W  current score, binary, from the score counter.
bcd  out  DIGITS*4  converted score; bcd[3:0] = units, [7:4] = tens, [11:8] = hundreds.
bcd_valid  out  1  one-cycle pulse when bcd is updated.
busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset values: bcd=0, bcd_valid=0, busy=0. Internal last_score=0, FSM=IDLE, shift count=0. Because the score also resets to 0, no conversion is needed after reset.
- IDLE: busy=0. If score != last_score:
  - capture score into the binary shift register;
  - set last_score <= score;
  - clear the BCD accumulator and the count;
  - go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - add 3 to every accumulator nibble that is >=5;
  - shift {accumulator, binary} left by 1;
  - count++.
  - After SCORE_W shifts, go to DONE.
- DONE: busy=1. bcd <= accumulator; bcd_valid=1 for this cycle only; go to IDLE.
- Latency: score change sampled at edge k -> bcd and bcd_valid change at edge k+SCORE_W+2 (10 cycles for SCORE_W=8). busy rises at edge k+1 and falls at edge k+SCORE_W+2.
- bcd holds its value between conversions and never shows partial results.
- Score changes while busy are ignored until return to IDLE. The value present in IDLE is then compared against last_score, so only the latest value is converted and intermediate values are dropped.
- Score returning to last_score during busy triggers no new conversion.
- Reset mid-conversion aborts immediately to reset values. bcd is cleared even if it previously held a non-zero score.
- Boundaries: score=0 -> 000; score=255 -> 255; no overflow, because the accumulator is DIGITS*4 bits wide.

Optional Feature:
SCORE_SEG7_EN
- Defined:
  - Adds outputs seg[6:0] (active-low, a..g), an[3:0] (active-low anodes) and dp (held 1, off).
  - A refresh counter of REFRESH_DIV cycles advances a digit slot 0..3. Slots 0..2 show units/tens/hundreds from bcd. Slot 3 is always blank (an[3]=1).
  - Leading-zero blanking: hundreds blanked when 0; tens blanked when hundreds and tens are both 0. Units are always shown.
  - Reset: seg=7'h7F, an=4'hF, slot=0, refresh counter=0.
- Undefined: these ports and the logic do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package score_pkg:
  - SCORE_W and BCD_W (=DIGITS*4) constants;
  - FSM state typedef {IDLE, SHIFT, DONE};
  - 7-segment pattern constants for 0-9 and blank.
- One natural sub-module, seg7_decoder: 4-bit BCD plus blank in -> seg[6:0] out. Purely combinational, instantiated only under SCORE_SEG7_EN.

Test Plan:
- Reset, hold score=0 for 20 cycles -> bcd=12'h000, bcd_valid never pulses, busy=0.
- Step score 0->7 at edge k -> busy=1 from k+1; bcd=12'h007 with a single bcd_valid pulse at k+10.
- Score=255, then score=100 after completion -> bcd=12'h255, then 12'h100; exactly two bcd_valid pulses.
- Score 5->6->9 during busy (changes at k+2 and k+4) -> first result 12'h005. A second conversion then gives 12'h009; value 6 is never output.
- Start conversion of 200, assert rst at k+4 for 1 cycle with score held at 0 -> bcd=0, busy=0, no bcd_valid pulse, no further conversion.
- With SCORE_SEG7_EN, REFRESH_DIV=4, score=42:
  - an cycles 1110, 1101, 1011, 1111 every 4 cycles;
  - seg shows '2', '4', blank (hundreds=0), blank.
